// File: rtl/timer_mode_ctrl.sv
// Mode controller and BCD time register for the mm:ss timer display.
// Debounces four active-low keys and sequences STOP/RUN/SET_SS/SET_MM.
module timer_mode_ctrl #(
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          DB_W            = 19,
    parameter logic [7:0]  PRESET_MM       = 8'h59
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [3:0]  KEY,
    input  logic        TICK,
    output logic [15:0] TIME_BCD,
    output logic [15:0] DIGIT,
    output logic [1:0]  MODE,
    output logic        LAP,
    output logic        WRAP
);

    typedef enum logic [1:0] {
        ST_STOP   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SET_SS = 2'd2,
        ST_SET_MM = 2'd3
    } mode_t;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Key path state
    logic [3:0]      sync1_q;
    logic [3:0]      sync2_q;
    logic [3:0]      db_q;
    logic [3:0]      press_q;
    logic [DB_W-1:0] cnt_q [4];

    // Timer state
    mode_t       mode_q, mode_n;
    logic [15:0] time_q, time_n;
    logic [15:0] snap_q, snap_n;
    logic [15:0] digit_q, digit_n;
    logic        lap_q, lap_n;
    logic        wrap_q, wrap_n;

    // Increment tree for the live time
    logic [7:0]  ss_inc, mm_inc;
    logic        ss_carry, mm_carry;
    logic [15:0] tick_time;
    logic        tick_wrap;

    // BCD 00..59 increment; bit 8 is the carry out of 59 -> 00.
    function automatic logic [8:0] bcd60_inc(input logic [7:0] v);
        logic [8:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) begin
                r = {1'b1, 8'h00};
            end else begin
                r = {1'b0, v[7:4] + 4'd1, 4'd0};
            end
        end else begin
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Synchronise, debounce and edge-detect each key. The press pulse is
    // registered on the same edge that the debounced level falls.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            db_q    <= 4'hF;
            press_q <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= KEY;
            sync2_q <= sync1_q;
            press_q <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DB_LAST) begin
                    cnt_q[i]   <= '0;
                    db_q[i]    <= sync2_q[i];
                    press_q[i] <= ~sync2_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign {ss_carry, ss_inc} = bcd60_inc(time_q[7:0]);
    assign {mm_carry, mm_inc} = bcd60_inc(time_q[15:8]);
    assign tick_time = ss_carry ? {mm_inc, ss_inc} : {time_q[15:8], ss_inc};
    assign tick_wrap = ss_carry & mm_carry;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode_q  <= ST_STOP;
            time_q  <= 16'h0000;
            snap_q  <= 16'h0000;
            digit_q <= 16'h0000;
            lap_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            mode_q  <= mode_n;
            time_q  <= time_n;
            snap_q  <= snap_n;
            digit_q <= digit_n;
            lap_q   <= lap_n;
            wrap_q  <= wrap_n;
        end
    end

    // Only the highest-priority press acts: P0 > P3 > P1 > P2.
    always_comb begin
        mode_n = mode_q;
        time_n = time_q;
        snap_n = snap_q;
        lap_n  = lap_q;
        wrap_n = 1'b0;

        if (press_q[0]) begin
            mode_n = ST_STOP;
            time_n = 16'h0000;
            lap_n  = 1'b0;
        end else if (press_q[3]) begin
            time_n = {PRESET_MM, 8'h00};
        end else if (press_q[1]) begin
            case (mode_q)
                ST_STOP: begin
                    mode_n = ST_RUN;
                end
                ST_RUN: begin
                    // A tick coinciding with the stop still counts.
                    mode_n = ST_STOP;
                    lap_n  = 1'b0;
                    if (TICK) begin
                        time_n = tick_time;
                        wrap_n = tick_wrap;
                    end
                end
                ST_SET_SS: begin
                    time_n[7:0] = ss_inc;
                end
                ST_SET_MM: begin
                    time_n[15:8] = mm_inc;
                end
                default: begin
                    mode_n = ST_STOP;
                end
            endcase
        end else if (press_q[2]) begin
            case (mode_q)
                ST_STOP:   mode_n = ST_SET_SS;
                ST_SET_SS: mode_n = ST_SET_MM;
                ST_SET_MM: mode_n = ST_STOP;
                ST_RUN: begin
                    lap_n = ~lap_q;
                    if (!lap_q) begin
                        snap_n = time_q;
                    end
                    if (TICK) begin
                        time_n = tick_time;
                        wrap_n = tick_wrap;
                    end
                end
                default: mode_n = ST_STOP;
            endcase
        end else if (mode_q == ST_RUN && TICK) begin
            time_n = tick_time;
            wrap_n = tick_wrap;
        end

        digit_n = lap_n ? snap_n : time_n;
    end

    assign TIME_BCD = time_q;
    assign DIGIT    = digit_q;
    assign MODE     = mode_q;
    assign LAP      = lap_q;
    assign WRAP     = wrap_q;

endmodule

// File: tb/tb_timer_mode_ctrl.sv
// Directed bench for timer_mode_ctrl with short debounce (4 cycles).
module tb_timer_mode_ctrl;

    logic        CLK;
    logic        RST_N;
    logic [3:0]  KEY;
    logic        TICK;
    logic [15:0] TIME_BCD;
    logic [15:0] DIGIT;
    logic [1:0]  MODE;
    logic        LAP;
    logic        WRAP;

    int passed = 0;
    int total  = 0;

    timer_mode_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .DB_W(3),
        .PRESET_MM(8'h59)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .KEY(KEY),
        .TICK(TICK),
        .TIME_BCD(TIME_BCD),
        .DIGIT(DIGIT),
        .MODE(MODE),
        .LAP(LAP),
        .WRAP(WRAP)
    );

    // Clock and reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Hold a key long enough for the action (7 edges), then release and settle.
    task automatic press(input int k);
        KEY[k] = 1'b0;
        cyc(7);
        KEY[k] = 1'b1;
        cyc(8);
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            TICK = 1'b1;
            cyc(1);
            TICK = 1'b0;
            cyc(1);
        end
    endtask

    initial begin
        RST_N = 1'b0;
        KEY   = 4'hF;
        TICK  = 1'b0;
        cyc(3);
        chk("rst_time",  TIME_BCD, 16'h0000);
        chk("rst_digit", DIGIT, 16'h0000);
        chk("rst_mode",  {14'd0, MODE}, 16'd0);
        chk("rst_lap",   {15'd0, LAP}, 16'd0);
        chk("rst_wrap",  {15'd0, WRAP}, 16'd0);
        RST_N = 1'b1;
        cyc(2);

        // Reset in the middle of a run at 00:37
        press(1);
        chk("run_mode", {14'd0, MODE}, 16'd1);
        tick_n(37);
        chk("time_37", TIME_BCD, 16'h0037);
        chk("digit_37", DIGIT, 16'h0037);
        #2 RST_N = 1'b0;
        #1;
        chk("async_time", TIME_BCD, 16'h0000);
        chk("async_mode", {14'd0, MODE}, 16'd0);
        chk("async_lap",  {15'd0, LAP}, 16'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        cyc(2);
        tick_n(20);
        chk("stop_ticks", TIME_BCD, 16'h0000);

        // Bounce rejection, then exact press latency
        KEY[1] = 1'b0;
        cyc(3);
        KEY[1] = 1'b1;
        cyc(1);
        KEY[1] = 1'b0;
        cyc(6);
        chk("bounce_stop", {14'd0, MODE}, 16'd0);
        cyc(1);
        chk("latency_run", {14'd0, MODE}, 16'd1);
        KEY[1] = 1'b1;
        cyc(8);

        // Preset in RUN, advance to 59:58, then roll over
        press(3);
        chk("preset_run", TIME_BCD, 16'h5900);
        chk("preset_mode", {14'd0, MODE}, 16'd1);
        tick_n(58);
        chk("time_5958", TIME_BCD, 16'h5958);
        TICK = 1'b1;
        cyc(1);
        TICK = 1'b0;
        chk("time_5959", TIME_BCD, 16'h5959);
        chk("wrap_pre", {15'd0, WRAP}, 16'd0);
        cyc(1);
        TICK = 1'b1;
        cyc(1);
        TICK = 1'b0;
        chk("time_wrap", TIME_BCD, 16'h0000);
        chk("wrap_pulse", {15'd0, WRAP}, 16'd1);
        cyc(1);
        chk("wrap_clear", {15'd0, WRAP}, 16'd0);

        // Field setting
        press(1);
        chk("stop_again", {14'd0, MODE}, 16'd0);
        press(2);
        chk("set_ss", {14'd0, MODE}, 16'd2);
        tick_n(2);
        chk("set_no_tick", TIME_BCD, 16'h0000);
        repeat (61) press(1);
        chk("ss_61", TIME_BCD, 16'h0001);
        press(2);
        chk("set_mm", {14'd0, MODE}, 16'd3);
        repeat (3) press(1);
        chk("mm_3", TIME_BCD, 16'h0301);
        press(2);
        chk("set_exit", {14'd0, MODE}, 16'd0);

        // Lap freeze
        press(0);
        chk("clear", TIME_BCD, 16'h0000);
        press(1);
        tick_n(10);
        chk("time_10", TIME_BCD, 16'h0010);
        press(2);
        chk("lap_set", {15'd0, LAP}, 16'd1);
        chk("lap_digit", DIGIT, 16'h0010);
        tick_n(5);
        chk("lap_time", TIME_BCD, 16'h0015);
        chk("lap_hold", DIGIT, 16'h0010);
        press(1);
        chk("lap_stop_mode", {14'd0, MODE}, 16'd0);
        chk("lap_stop_lap", {15'd0, LAP}, 16'd0);
        chk("lap_stop_digit", DIGIT, 16'h0015);

        // Clear and preset together with a tick in RUN
        press(1);
        tick_n(1);
        chk("time_16", TIME_BCD, 16'h0016);
        KEY = 4'b0110;
        cyc(6);
        TICK = 1'b1;
        cyc(1);
        TICK = 1'b0;
        chk("p0p3_time", TIME_BCD, 16'h0000);
        chk("p0p3_mode", {14'd0, MODE}, 16'd0);
        KEY = 4'hF;
        cyc(8);
        press(3);
        chk("preset_stop", TIME_BCD, 16'h5900);
        chk("preset_stop_mode", {14'd0, MODE}, 16'd0);

        // Start with a coincident tick: not counted
        KEY[1] = 1'b0;
        cyc(6);
        TICK = 1'b1;
        cyc(1);
        TICK = 1'b0;
        chk("start_tick_mode", {14'd0, MODE}, 16'd1);
        chk("start_tick_time", TIME_BCD, 16'h5900);
        KEY[1] = 1'b1;
        cyc(8);

        // Stop with a coincident tick: counted
        KEY[1] = 1'b0;
        cyc(6);
        TICK = 1'b1;
        cyc(1);
        TICK = 1'b0;
        chk("stop_tick_mode", {14'd0, MODE}, 16'd0);
        chk("stop_tick_time", TIME_BCD, 16'h5901);
        KEY[1] = 1'b1;
        cyc(8);

        // P1 outranks P2 in the same cycle
        KEY = 4'b1001;
        cyc(7);
        chk("p1_over_p2", {14'd0, MODE}, 16'd1);
        KEY = 4'hF;
        cyc(8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
